stepper_ctrl: RTL

STEPPER_CTRL -- requirements
Module: stepper_ctrl

---
 rtl/stepper_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/stepper_ctrl.sv
// Stepper motor controller: accepts absolute move and homing commands,
// paces steps with a programmable clock divider and drives a 4-wire coil
// pattern in full-step or half-step sequence.
module stepper_ctrl #(
   parameter int POS_W     = 16,
   parameter int DIV_W     = 16,
   parameter int HALF_STEP = 0,
   parameter int HOME_MAX  = 4096,
   parameter int HOLD      = 1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_home,
   input  logic signed [POS_W-1:0] cmd_target,
   input  logic [DIV_W-1:0]        cmd_period,
   input  logic                    limit_switch,
   output logic [3:0]              coil,
   output logic                    dir,
   output logic signed [POS_W-1:0] position,
   output logic                    busy,
   output logic                    done,
   output logic                    err
);

   localparam int HC_W = $clog2(HOME_MAX + 1);
   localparam logic [3:0] COIL_RST = (HOLD != 0) ? 4'b1100 : 4'b0000;

   typedef enum logic [1:0] {IDLE, MOVE, HOME, DONE} state_t;

   state_t                  state_q, state_d;
   logic signed [POS_W-1:0] position_q, position_d;
   logic signed [POS_W-1:0] target_q, target_d;
   logic [2:0]              phase_q, phase_d;
   logic                    dir_q, dir_d;
   logic [DIV_W-1:0]        timer_q, timer_d;
   logic [DIV_W-1:0]        period_q, period_d;
   logic [HC_W-1:0]         home_cnt_q, home_cnt_d;
   logic                    err_q, err_d;
   logic [3:0]              coil_q, coil_d;
   logic                    lim_meta_q, lim_s_q;
   logic                    lim_s;
   logic                    step_tick;
   logic [2:0]              phase_next;
   logic signed [POS_W-1:0] pos_next;

   // Winding pattern for a phase index; full-step uses only the low two bits.
   function automatic logic [3:0] coil_of(input logic [2:0] ph);
      logic [3:0] pat;
      if (HALF_STEP != 0) begin
         case (ph)
            3'd0:    pat = 4'b1000;
            3'd1:    pat = 4'b1100;
            3'd2:    pat = 4'b0100;
            3'd3:    pat = 4'b0110;
            3'd4:    pat = 4'b0010;
            3'd5:    pat = 4'b0011;
            3'd6:    pat = 4'b0001;
            default: pat = 4'b1001;
         endcase
      end else begin
         case (ph[1:0])
            2'd0:    pat = 4'b1100;
            2'd1:    pat = 4'b0110;
            2'd2:    pat = 4'b0011;
            default: pat = 4'b1001;
         endcase
      end
      return pat;
   endfunction

   // Two-flop synchroniser so the asynchronous home switch never reaches the FSM raw.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         lim_meta_q <= 1'b0;
         lim_s_q    <= 1'b0;
      end else begin
         lim_meta_q <= limit_switch;
         lim_s_q    <= lim_meta_q;
      end
   end

   assign lim_s = lim_s_q;

   // Controller state register; coil is registered so the reset pattern is exact in every mode.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         position_q <= '0;
         target_q   <= '0;
         phase_q    <= 3'd0;
         dir_q      <= 1'b0;
         timer_q    <= '0;
         period_q   <= DIV_W'(1);
         home_cnt_q <= '0;
         err_q      <= 1'b0;
         coil_q     <= COIL_RST;
      end else begin
         state_q    <= state_d;
         position_q <= position_d;
         target_q   <= target_d;
         phase_q    <= phase_d;
         dir_q      <= dir_d;
         timer_q    <= timer_d;
         period_q   <= period_d;
         home_cnt_q <= home_cnt_d;
         err_q      <= err_d;
         coil_q     <= coil_d;
      end
   end

   // Next-state logic: command acceptance, step pacing, limit handling and homing timeout.
   always_comb begin
      state_d    = state_q;
      position_d = position_q;
      target_d   = target_q;
      phase_d    = phase_q;
      dir_d      = dir_q;
      timer_d    = timer_q;
      period_d   = period_q;
      home_cnt_d = home_cnt_q;
      err_d      = err_q;

      step_tick  = (timer_q == (period_q - DIV_W'(1)));
      phase_next = dir_q ? (phase_q - 3'd1) : (phase_q + 3'd1);
      if (HALF_STEP == 0) begin
         phase_next[2] = 1'b0;
      end
      pos_next = dir_q ? (position_q - POS_W'(1)) : (position_q + POS_W'(1));

      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               err_d      = 1'b0;
               target_d   = cmd_target;
               period_d   = (cmd_period == '0) ? DIV_W'(1) : cmd_period;
               timer_d    = '0;
               home_cnt_d = '0;
               if (cmd_home) begin
                  dir_d   = 1'b1;
                  state_d = HOME;
               end else if (cmd_target == position_q) begin
                  state_d = DONE;
               end else begin
                  dir_d   = (cmd_target < position_q);
                  state_d = MOVE;
               end
            end
         end
         MOVE: begin
            if (dir_q && lim_s) begin
               position_d = '0;
               state_d    = DONE;
            end else if (step_tick) begin
               timer_d    = '0;
               position_d = pos_next;
               phase_d    = phase_next;
               if (pos_next == target_q) begin
                  state_d = DONE;
               end
            end else begin
               timer_d = timer_q + DIV_W'(1);
            end
         end
         HOME: begin
            if (lim_s) begin
               position_d = '0;
               state_d    = DONE;
            end else if (step_tick) begin
               timer_d    = '0;
               position_d = pos_next;
               phase_d    = phase_next;
               home_cnt_d = home_cnt_q + HC_W'(1);
               if (home_cnt_q == HC_W'(HOME_MAX - 1)) begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end
            end else begin
               timer_d = timer_q + DIV_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      coil_d = ((HOLD == 0) && (state_d == IDLE)) ? 4'b0000 : coil_of(phase_d);
   end

   assign cmd_ready = (state_q == IDLE);
   assign busy      = (state_q == MOVE) || (state_q == HOME);
   assign done      = (state_q == DONE);
   assign coil      = coil_q;
   assign dir       = dir_q;
   assign position  = position_q;
   assign err       = err_q;

endmodule
